// File: rtl/gene_sweep_ctrl.sv
// Sweep controller for a boolean gene network: walks every initial state through the
// external next-state logic and classifies each trajectory as fixed point, 2-cycle or timeout.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | present the next initial state, clear trajectory history
// RUN    | step the network one transition per cycle, watch for attractors
// REPORT | hold the result until the consumer takes it
// DONE   | one-cycle completion pulse
module gene_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int MAX_STEPS = 16,
    localparam int STEP_W = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WIDTH-1:0]  state_out,
    input  logic [WIDTH-1:0]  next_x,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_init,
    output logic [1:0]        res_kind,
    output logic [STEP_W-1:0] res_steps,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT,
        S_DONE
    } state_t;

    localparam logic [STEP_W-1:0] STEP_MAX     = STEP_W'(MAX_STEPS);
    localparam logic [1:0]        KIND_FIXED   = 2'b00;
    localparam logic [1:0]        KIND_CYCLE   = 2'b01;
    localparam logic [1:0]        KIND_TIMEOUT = 2'b10;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]  init_cnt;
    logic [WIDTH-1:0]  prev;
    logic              prev_valid;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_inc;

    logic is_fixed;
    logic is_cycle;
    logic is_timeout;
    logic transfer;
    logic last_init;

    assign step_inc   = step + STEP_W'(1);
    assign is_fixed   = (next_x == state_out);
    // A fixed point always wins over the 2-cycle check.
    assign is_cycle   = prev_valid && (next_x == prev) && !is_fixed;
    assign is_timeout = (step_inc == STEP_MAX);
    assign transfer   = (state == S_REPORT) && res_ready;
    assign last_init  = (init_cnt == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (is_fixed || is_cycle || is_timeout) begin
                    state_nx = S_REPORT;
                end
            end
            S_REPORT: begin
                if (transfer) begin
                    state_nx = last_init ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        if (state != S_IDLE) begin
            busy = 1'b1;
        end
        if (state == S_REPORT) begin
            res_valid = 1'b1;
        end
        if (state == S_DONE) begin
            done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt   <= '0;
            state_out  <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            step       <= '0;
            res_init   <= '0;
            res_kind   <= '0;
            res_steps  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        init_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    state_out  <= init_cnt;
                    prev_valid <= 1'b0;
                    step       <= '0;
                end
                S_RUN: begin
                    if (is_fixed) begin
                        res_init  <= init_cnt;
                        res_kind  <= KIND_FIXED;
                        res_steps <= step_inc;
                    end else if (is_cycle) begin
                        res_init  <= init_cnt;
                        res_kind  <= KIND_CYCLE;
                        res_steps <= step_inc;
                    end else if (is_timeout) begin
                        res_init  <= init_cnt;
                        res_kind  <= KIND_TIMEOUT;
                        res_steps <= STEP_MAX;
                    end else begin
                        prev       <= state_out;
                        prev_valid <= 1'b1;
                        state_out  <= next_x;
                        step       <= step_inc;
                    end
                end
                S_REPORT: begin
                    // The last initial state ends the sweep instead of wrapping to zero.
                    if (transfer && !last_init) begin
                        init_cnt <= init_cnt + WIDTH'(1);
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gene_sweep_ctrl.sv
// Bench for gene_sweep_ctrl: drives the network next-state function from a selectable map
// and compares every cycle against a trajectory-level reference model.
module tb_gene_sweep_ctrl;

    localparam int W  = 8;
    localparam int MS = 16;
    localparam int SW = $clog2(MS + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  state_out;
    logic [W-1:0]  next_x;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_init;
    logic [1:0]    res_kind;
    logic [SW-1:0] res_steps;
    logic          done;

    gene_sweep_ctrl #(.WIDTH(W), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .state_out(state_out), .next_x(next_x),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_kind(res_kind), .res_steps(res_steps),
        .done(done)
    );

    always #5 clk = ~clk;

    int           mode = 0;
    logic [W-1:0] lut [256];

    function automatic logic [W-1:0] net_f(input int m, input logic [W-1:0] x);
        case (m)
            0:       return x;
            1:       return ~x;
            2:       return x + 8'd1;
            default: return lut[x];
        endcase
    endfunction

    assign next_x = net_f(mode, state_out);

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: walk the trajectory with plain arithmetic and classify it.
    int           exp_kind;
    int           exp_steps;
    logic [W-1:0] traj [MS];

    function automatic void compute(input int m, input int init);
        logic [W-1:0] x;
        logic [W-1:0] p;
        logic [W-1:0] n;
        bit           hp;
        x  = init[W-1:0];
        p  = '0;
        hp = 1'b0;
        for (int s = 0; s < MS; s++) begin
            traj[s] = x;
            n = net_f(m, x);
            if (n == x) begin
                exp_kind = 0; exp_steps = s + 1; return;
            end
            if (hp && n == p) begin
                exp_kind = 1; exp_steps = s + 1; return;
            end
            p  = x;
            x  = n;
            hp = 1'b1;
        end
        exp_kind  = 2;
        exp_steps = MS;
    endfunction

    int cyc = 0;
    bit rst_q, start_q, ready_q;

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_q   = rst;
        start_q = start;
        ready_q = res_ready;
    end

    // Model state: 0 idle, 1 sweeping, 2 done cycle.
    int ms = 0;
    int cur_init = 0;
    int ref_c = 0;
    int done_cnt = 0;

    initial forever begin
        int k;
        @(negedge clk);
        if (cyc > 0) begin
            if (done === 1'b1) done_cnt++;
            if (rst_q) begin
                ms = 0;
                chk("rst_state_out", 32'(state_out), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_valid", 32'(res_valid), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_res_init", 32'(res_init), 0);
                chk("rst_res_kind", 32'(res_kind), 0);
                chk("rst_res_steps", 32'(res_steps), 0);
            end else begin
                case (ms)
                    0: if (start_q) begin
                        ms = 1; cur_init = 0; ref_c = cyc; compute(mode, 0);
                    end
                    1: if ((cyc - 1 - ref_c) > exp_steps && ready_q) begin
                        if (cur_init == 255) ms = 2;
                        else begin
                            cur_init++; ref_c = cyc; compute(mode, cur_init);
                        end
                    end
                    default: ms = 0;
                endcase
                k = cyc - ref_c;
                if (ms == 0) begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_valid", 32'(res_valid), 0);
                    chk("idle_done", 32'(done), 0);
                end else if (ms == 2) begin
                    chk("done_pulse", 32'(done), 1);
                    chk("done_busy", 32'(busy), 1);
                    chk("done_valid", 32'(res_valid), 0);
                end else begin
                    chk("act_busy", 32'(busy), 1);
                    chk("act_done", 32'(done), 0);
                    if (k == 0) begin
                        chk("load_valid", 32'(res_valid), 0);
                    end else if (k <= exp_steps) begin
                        chk("run_valid", 32'(res_valid), 0);
                        chk("run_state_out", 32'(state_out), 32'(traj[k-1]));
                    end else begin
                        chk("rep_valid", 32'(res_valid), 1);
                        chk("rep_init", 32'(res_init), 32'(cur_init));
                        chk("rep_kind", 32'(res_kind), 32'(exp_kind));
                        chk("rep_steps", 32'(res_steps), 32'(exp_steps));
                    end
                end
            end
        end
    end

    task automatic run_sweep(input int m, input int rmode);
        int d0;
        int hold;
        int n;
        bit got;
        mode = m;
        d0   = done_cnt;
        hold = 0;
        @(posedge clk); #1 start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20000) begin
            if (rmode == 0) res_ready = 1'b1;
            else if (rmode == 1) res_ready = 1'($urandom_range(0, 1));
            else begin
                if (!res_valid) hold = 0;
                res_ready = (hold >= 5);
                if (res_valid) hold++;
            end
            start = (ms == 1) && ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            n++;
            if (done_cnt != d0) got = 1'b1;
        end
        start = 1'b0;
        if (!got) chk("sweep_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt - d0), 1);
    endtask

    task automatic reset_mid_run();
        int n;
        mode = 2;
        res_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(ms == 1 && cur_init == 5 && (cyc - ref_c) == 3) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_init5", 32'(n < 2000), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;

        compute(0, 9);
        chk("pin_ident_kind", 32'(exp_kind), 0);
        chk("pin_ident_steps", 32'(exp_steps), 1);
        compute(1, 0);
        chk("pin_inv_kind", 32'(exp_kind), 1);
        chk("pin_inv_steps", 32'(exp_steps), 2);
        chk("pin_inv_traj1", 32'(traj[1]), 32'hFF);
        compute(2, 7);
        chk("pin_inc_kind", 32'(exp_kind), 2);
        chk("pin_inc_steps", 32'(exp_steps), 16);
        for (int i = 0; i < 256; i++) lut[i] = 8'(i);
        lut[0] = 8'd3; lut[3] = 8'd7; lut[7] = 8'd7;
        compute(3, 0);
        chk("pin_lut_kind", 32'(exp_kind), 0);
        chk("pin_lut_steps", 32'(exp_steps), 3);

        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       lut[i] = 8'(i);
                1:       lut[i] = 8'(i) ^ 8'h01;
                default: lut[i] = 8'($urandom_range(0, 255));
            endcase
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_sweep(0, 0);
        run_sweep(1, 2);
        run_sweep(2, 0);
        run_sweep(3, 1);
        reset_mid_run();
        run_sweep(1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
